// File: rtl/bcd_tick_counter.sv
// Packed-BCD counter of rising edges on a sampled divided tick, with start/stop/clear control.
// Define TICK_SYNC_EN to pass clk_div_10 through a 2-flop synchronizer before edge detection.
module bcd_tick_counter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_div_10,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count_out,
  output logic                  running,
  output logic                  tick_seen,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StRun, StHold, StSat} state_e;

  state_e         r_state, w_state_next;
  logic [W-1:0]   r_count, w_count_next, w_inc;
  logic           r_prev, r_tick, r_carry, r_ovf;
  logic           w_tick_next, w_carry_next, w_ovf_next;
  logic           w_tick_in, w_edge, w_all9;

`ifdef TICK_SYNC_EN
  logic [1:0] r_sync;

  // Resets high so a tick already high at release does not look like an edge.
  always_ff @(posedge clk) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], clk_div_10};
  end

  assign w_tick_in = r_sync[1];
`else
  assign w_tick_in = clk_div_10;
`endif

  assign w_edge = w_tick_in & ~r_prev;

  always_comb begin
    logic c;
    c      = 1'b1;
    w_inc  = r_count;
    w_all9 = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_count[4*i +: 4] != 4'd9) w_all9 = 1'b0;
      if (c) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          c               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_tick_next  = 1'b0;
    w_carry_next = 1'b0;
    w_ovf_next   = r_ovf;
    if (clear) begin
      w_state_next = StIdle;
      w_count_next = '0;
      w_ovf_next   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StHold: begin
          // Stop outranks start; an edge coincident with start is not counted.
          if (start && !stop) w_state_next = StRun;
        end
        StRun: begin
          if (w_edge) begin
            w_tick_next = 1'b1;
            if (w_all9) begin
              w_carry_next = 1'b1;
              w_ovf_next   = 1'b1;
              if (WRAP != 0) w_count_next = '0;
              else           w_state_next = StSat;
            end else begin
              w_count_next = w_inc;
            end
          end
          if (stop && w_state_next == StRun) w_state_next = StHold;
        end
        StSat: begin
          w_state_next = StSat;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_count <= '0;
      r_prev  <= 1'b1;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_prev  <= w_tick_in;
      r_tick  <= w_tick_next;
      r_carry <= w_carry_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign count_out = r_count;
  assign running   = (r_state == StRun);
  assign tick_seen = r_tick;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;

endmodule
